// File: rtl/reg_scoreboard_if.sv
// Issue, write-back and squash signal bundle for the register scoreboard.
// The master side is decode/issue plus the retire paths; the slave side is
// the scoreboard itself.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int STALL_W  = 32
);
  localparam int AW = $clog2(NUM_REGS);

  logic                issue_valid;
  logic [AW-1:0]       issue_rs1;
  logic                issue_rs1_used;
  logic [AW-1:0]       issue_rs2;
  logic                issue_rs2_used;
  logic [AW-1:0]       issue_rd;
  logic                issue_rd_write;
  logic                issue_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic                squash_valid;
  logic [AW-1:0]       squash_rd;
  logic [NUM_REGS-1:0] busy_mask;
  logic [STALL_W-1:0]  stall_count;
  logic                err;

  modport master (
    output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
    output issue_rd, issue_rd_write, wb_valid, wb_rd, squash_valid, squash_rd,
    input  issue_ready, busy_mask, stall_count, err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
    input  issue_rd, issue_rd_write, wb_valid, wb_rd, squash_valid, squash_rd,
    output issue_ready, busy_mask, stall_count, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-read hazard tracker: counts in-flight writers per architectural
// register, holds issue while a source still has a pending writer, and lets
// a same-cycle write-back or squash clear that hazard immediately because
// the register file writes in the first half of the cycle.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 32
) (
  input logic             clk,
  input logic             reset,
  reg_scoreboard_if.slave sb
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    count_q [NUM_REGS];
  logic [CNT_W-1:0]    count_d [NUM_REGS];
  logic [STALL_W-1:0]  stall_q;
  logic [STALL_W-1:0]  stall_d;
  logic                err_q;
  logic                err_d;
  logic [1:0]          ret_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] eff_nz;
  logic                hazard_rs1;
  logic                hazard_rs2;
  logic                sat_hazard;
  logic                ready;
  logic                fire;

  // Retirements landing on each register this cycle, and whether a writer remains after them
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      ret_cnt[r] = 2'b00;
      eff_nz[r]  = 1'b0;
      if (r != 0) begin
        ret_cnt[r] = {1'b0, sb.wb_valid && (sb.wb_rd == AW'(r))}
                   + {1'b0, sb.squash_valid && (sb.squash_rd == AW'(r))};
        eff_nz[r]  = ({2'b00, count_q[r]} > {{CNT_W{1'b0}}, ret_cnt[r]});
      end
    end
  end

  // Issue gating: source hazards see same-cycle retirement, saturation uses only the registered count
  always_comb begin
    hazard_rs1 = sb.issue_rs1_used && (sb.issue_rs1 != '0) && eff_nz[sb.issue_rs1];
    hazard_rs2 = sb.issue_rs2_used && (sb.issue_rs2 != '0) && eff_nz[sb.issue_rs2];
    sat_hazard = sb.issue_rd_write && (sb.issue_rd != '0) && (count_q[sb.issue_rd] == CNT_MAX);
    ready      = !reset && !hazard_rs1 && !hazard_rs2 && !sat_hazard;
    fire       = sb.issue_valid && ready;
  end

  // Next counter values, sticky underflow flag and saturating stall counter
  always_comb begin : next_state_c
    logic [CNT_W+1:0] up;
    logic [CNT_W+1:0] dn;
    logic [CNT_W+1:0] diff;
    err_d   = err_q;
    stall_d = stall_q;
    up      = '0;
    dn      = '0;
    diff    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d[r] = '0;
      if (r != 0) begin
        up   = {2'b00, count_q[r]}
             + {{(CNT_W+1){1'b0}}, fire && sb.issue_rd_write && (sb.issue_rd == AW'(r))};
        dn   = {{CNT_W{1'b0}}, ret_cnt[r]};
        diff = up - dn;
        if (dn > up) begin
          err_d = 1'b1;
        end else begin
          count_d[r] = diff[CNT_W-1:0];
        end
      end
    end
    if (sb.issue_valid && !ready && !reset && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // Outputs: busy mask straight from the registered counts, no bypass
  always_comb begin
    sb.issue_ready = ready;
    sb.busy_mask   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sb.busy_mask[r] = (count_q[r] != '0);
    end
    sb.stall_count = stall_q;
    sb.err         = err_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        count_q[r] <= '0;
      end
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        count_q[r] <= count_d[r];
      end
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-read-side hazard tracker for the pipelined RV32 core. It sits between decode/issue and the register file.
- Keeps a per-register count of in-flight writers. It stalls issue while any source operand has a pending write, and releases it when write-back (or a squash) retires that writer.
- The register file writes in the first half-cycle, so an operand that retires in the same cycle it is read is safe to read.

Parameters:
- NUM_REGS, 32, number of architectural registers (x0 never tracked)
- CNT_W, 2, width of each pending-writer counter (max 2^CNT_W-1 in flight per register)
- STALL_W, 32, width of the stall performance counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- issue_valid  input  1  decode has an instruction ready to issue
- issue_rs1  input  5  source register 1
- issue_rs1_used  input  1  instruction reads rs1
- issue_rs2  input  5  source register 2
- issue_rs2_used  input  1  instruction reads rs2
- issue_rd  input  5  destination register
- issue_rd_write  input  1  instruction writes rd (RegWrite)
- issue_ready  output  1  combinational; issue may proceed this cycle
- wb_valid  input  1  write-back stage writes wb_rd this cycle
- wb_rd  input  5  write-back destination
- squash_valid  input  1  a killed in-flight writer is retired without writing
- squash_rd  input  5  destination of the squashed writer
- busy_mask  output  NUM_REGS  bit i = (count[i] != 0), taken from registered state
- stall_count  output  STALL_W  cycles with issue_valid & !issue_ready
- err  output  1  sticky; a decrement hit a zero counter

Behaviour:
- Reset (reset=1 at a rising edge):
  - all counters, busy_mask, stall_count and err are cleared to 0.
  - While reset is high, issue_ready=0 and all wb/squash/issue inputs are ignored.
- Fire: fire = issue_valid & issue_ready.
- Source hazard for rsN: asserted when rsN_used & rsN!=0 & eff[rsN]!=0.
  - eff[r] = count[r] - (wb_valid & wb_rd==r) - (squash_valid & squash_rd==r), floored at 0.
  - Same-cycle retirement therefore clears the hazard with zero-cycle latency.
- Saturation hazard: asserted when issue_rd_write & issue_rd!=0 & count[issue_rd]==2^CNT_W-1. This uses the registered count; same-cycle retirement does not relieve it.
- issue_ready = !reset & !hazard_rs1 & !hazard_rs2 & !saturation_hazard. It is independent of issue_valid.
- Counter update at each edge, per register r != 0:
  - next = count[r] + inc - dec_wb - dec_sq.
  - inc = fire & issue_rd_write & issue_rd==r.
  - dec_wb and dec_sq are the wb and squash matches on r.
  - wb and squash matching the same r both apply (net -2).
  - Issue and retire to the same r in one cycle apply together (net 0 or -1).
- Underflow: if the total decrement exceeds count[r], the counter is set to 0 and err is set (sticky until reset). No other state is affected.
- x0: the issue, wb and squash paths ignore rd=0. count[0] stays 0 and busy_mask[0] stays 0.
- busy_mask reflects counts after the last edge. It has 1-cycle latency and no same-cycle bypass.
- stall_count increments on each edge where issue_valid & !issue_ready & !reset. It saturates at all-ones.
- No internal FSM beyond counters. Scoreboard correctness relies on every issued writer eventually producing exactly one wb or squash.

Test Plan:
- Reset, then issue rd=5 (write) with no sources → issue_ready=1 and fire. Next cycle busy_mask=0x00000020.
- RAW stall, with count[5]=1:
  - Issue rs1=5 → issue_ready=0 and stall_count increments each cycle.
  - Assert wb_valid, wb_rd=5 → issue_ready=1 the same cycle.
  - Next edge → count[5]=0, busy_mask[5]=0.
- x0 and unused operands:
  - Issue rd=0, rs1=0 repeatedly → busy_mask stays 0 and issue_ready stays 1.
  - rs2=5 with issue_rs2_used=0 while x5 is busy → issue_ready=1.
- Saturation (CNT_W=2):
  - Fire three writes to x7 → count=3.
  - A fourth write to x7 → issue_ready=0, even with a same-cycle wb to x7.
  - Next cycle (count=2) → the fourth issue fires.
- Simultaneous events and error:
  - count[9]=2; wb and squash both on x9 in one cycle → count=0, err=0.
  - A further wb_rd=9 → err=1 and it stays set.
  - Reset → err=0, stall_count=0.
- Reset mid-operation: with busy registers, assert reset while issue_valid=1 → issue_ready=0 and no fire. After release, busy_mask=0.
